// File: rtl/esaxi_emesh_tx_arb_if.sv
// eMesh transmit-side bundle: write and read request streams in, one packet stream out.
// The slave modport is the arbiter's view of the bundle, and the master modport is the view of the surrounding logic.
interface esaxi_emesh_tx_arb_if #(
  parameter int PW = 104
);
  logic          wr_access;
  logic [PW-1:0] wr_packet;
  logic          wr_wait;
  logic          rd_access;
  logic [PW-1:0] rd_packet;
  logic          rd_wait;
  logic          tx_access;
  logic [PW-1:0] tx_packet;
  logic          tx_wait;
  logic          arb_busy;
  logic          last_src;

  modport slave (
    input  wr_access, wr_packet, rd_access, rd_packet, tx_wait,
    output wr_wait, rd_wait, tx_access, tx_packet, arb_busy, last_src
  );

  modport master (
    output wr_access, wr_packet, rd_access, rd_packet, tx_wait,
    input  wr_wait, rd_wait, tx_access, tx_packet, arb_busy, last_src
  );
endinterface

// File: rtl/esaxi_emesh_tx_arb.sv
// Write-priority arbiter with a bounded write run, which shares the eMesh tx channel between
// the AXI write and read-request streams. A one-deep registered output stage honours tx_wait.
module esaxi_emesh_tx_arb #(
  parameter int PW      = 104,
  parameter int RUN_MAX = 4,
  parameter int CW      = 4
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  esaxi_emesh_tx_arb_if.slave   bus
);

  localparam logic [CW-1:0] RUN_MAX_C = CW'(RUN_MAX);

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_WR   = 2'b01,
    SEL_RD   = 2'b10
  } sel_e;

  logic          tx_access_r;
  logic [PW-1:0] tx_packet_r;
  logic          last_src_r;
  logic [CW-1:0] run_r;

  sel_e          sel_s;
  logic          load_s;
  logic          wr_acc_s;
  logic          rd_acc_s;

  // Grant selection and accept qualification; waits stay high while reset is asserted
  always_comb begin
    load_s   = ~tx_access_r | ~bus.tx_wait;
    sel_s    = SEL_NONE;
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    case ({bus.wr_access, bus.rd_access})
      2'b11:   sel_s = (run_r == RUN_MAX_C) ? SEL_RD : SEL_WR;
      2'b10:   sel_s = SEL_WR;
      2'b01:   sel_s = SEL_RD;
      default: sel_s = SEL_NONE;
    endcase
    if (s_axi_aresetn && load_s) begin
      wr_acc_s = (sel_s == SEL_WR);
      rd_acc_s = (sel_s == SEL_RD);
    end else begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end
  end

  assign bus.wr_wait   = ~wr_acc_s;
  assign bus.rd_wait   = ~rd_acc_s;
  assign bus.tx_access = tx_access_r;
  assign bus.tx_packet = tx_packet_r;
  assign bus.last_src  = last_src_r;
  assign bus.arb_busy  = tx_access_r | bus.wr_access | bus.rd_access;

  // Output stage: load on accept, empty when drained with nothing granted, hold while stalled
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      tx_access_r <= 1'b0;
      tx_packet_r <= {PW{1'b0}};
      last_src_r  <= 1'b0;
    end else if (wr_acc_s) begin
      tx_access_r <= 1'b1;
      tx_packet_r <= bus.wr_packet;
      last_src_r  <= 1'b0;
    end else if (rd_acc_s) begin
      tx_access_r <= 1'b1;
      tx_packet_r <= bus.rd_packet;
      last_src_r  <= 1'b1;
    end else if (load_s) begin
      tx_access_r <= 1'b0;
    end else begin
      tx_access_r <= tx_access_r;
    end
  end

  // Run counter: consecutive write grants made while a read waits, cleared by any read or an uncontested write
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      run_r <= {CW{1'b0}};
    end else if (wr_acc_s) begin
      if (!bus.rd_access) begin
        run_r <= {CW{1'b0}};
      end else if (run_r != RUN_MAX_C) begin
        run_r <= run_r + CW'(1);
      end else begin
        run_r <= run_r;
      end
    end else if (rd_acc_s) begin
      run_r <= {CW{1'b0}};
    end else begin
      run_r <= run_r;
    end
  end

endmodule

// File: doc/esaxi_emesh_tx_arb.md
Name: esaxi_emesh_tx_arb

Overview:
- Shares the single eMesh transmit channel between the AXI slave's write-request stream (wr_access/wr_packet) and read-request stream (rd_access/rd_packet).
- Write-priority arbiter with a bounded run length, so reads cannot starve.
- Registered one-deep output stage honouring eMesh wait back-pressure.
- Sits between the AXI slave block and the eLink transmitter.

Parameters:
- PW, 104, eMesh packet width in bits.
- RUN_MAX, 4, maximum consecutive write grants while a read is pending (legal range 1..15).
- CW, 4, width of the run counter (must satisfy 2^CW > RUN_MAX).

Ports:
- s_axi_aclk  input  1  clock
- s_axi_aresetn  input  1  asynchronous active-low reset
- wr_access  input  1  write packet valid
- wr_packet  input  PW  write packet
- wr_wait  output  1  back-pressure to write source
- rd_access  input  1  read-request packet valid
- rd_packet  input  PW  read-request packet
- rd_wait  output  1  back-pressure to read source
- tx_access  output  1  registered packet valid to transmitter
- tx_packet  output  PW  registered packet
- tx_wait  input  1  back-pressure from transmitter
- arb_busy  output  1  tx_access OR wr_access OR rd_access
- last_src  output  1  source of the current/last tx packet: 0 = write, 1 = read

Behaviour:
- Clock and reset: one clock, s_axi_aclk. Reset is asynchronous and active-low on s_axi_aresetn.
- Reset values: tx_access = 0, tx_packet = 0, last_src = 0, run counter = 0.
- wr_wait and rd_wait are combinational. During reset, wr_wait = rd_wait = 1.
- Load enable: load = ~tx_access | ~tx_wait. The output register can take a new packet when it is empty or being drained this cycle.
- Grant selection (combinational):
  - Only wr_access: sel = WR.
  - Only rd_access: sel = RD.
  - Both: sel = RD if run == RUN_MAX, else WR.
  - Neither: no grant.
- Waits:
  - wr_wait = ~(load & sel==WR).
  - rd_wait = ~(load & sel==RD).
  - A source whose access is low may see wait = 1. Sources must hold access and packet stable while their wait is high.
- Transfer: a packet is accepted when access & ~wait. On accept, tx_packet <= selected packet, tx_access <= 1, last_src <= sel. Latency from accept to tx_access is 1 cycle.
- Drain: if load and no grant, tx_access <= 0. tx_packet holds its old value.
- Stall: if tx_access & tx_wait, tx_access and tx_packet hold and both waits are 1.
- Run counter, updated on accept only:
  - WR accepted while rd_access = 1: run <= run+1, saturating at RUN_MAX.
  - WR accepted while rd_access = 0: run <= 0.
  - RD accepted: run <= 0.
- Back-to-back: full throughput of one packet per cycle when tx_wait = 0.
- Ordering: packets from the same source leave in arrival order. No cross-source ordering is guaranteed.
- Simultaneous tx_wait rise and accept: tx_wait is sampled in the current cycle only. If tx_wait = 1 and tx_access = 1, no accept occurs.
- Reset mid-operation: any held packet is dropped and tx_access falls immediately (asynchronously). Upstream sources must also be reset.

Test Plan:
- Reset: assert s_axi_aresetn = 0 with wr_access = 1 -> tx_access = 0, wr_wait = rd_wait = 1, last_src = 0. Release -> first WR packet appears on tx_packet one cycle after accept.
- Write stream only: 8 back-to-back writes, tx_wait = 0 -> 8 consecutive tx_access cycles, packets in order, wr_wait = 0 throughout, run stays 0.
- Contention, RUN_MAX = 4: wr_access and rd_access held high with 6 writes and 2 reads, tx_wait = 0 -> tx source order W,W,W,W,R,W,W,R.
- Back-pressure: tx_wait = 1 for 3 cycles while tx_access = 1 with packet 0xA5 -> tx_packet stays 0xA5, wr_wait = rd_wait = 1. tx_wait falls -> next packet loads the same cycle.
- Read only with bubbles: rd_access pulses on alternate cycles -> tx_access follows delayed by 1, last_src = 1, tx_access = 0 in the gaps.
- Reset mid-stall: tx_access = 1, tx_wait = 1, then reset asserted -> tx_access = 0 asynchronously, run = 0. After release, a write is granted first.
